vga_frame_scheduler: RTL and testbench

//  640x480@60 Hz VGA timing controller and frame-memory access scheduler.

---
 rtl/vga_timing_pkg.sv | 17 +
 rtl/vga_sync_counter.sv | 70 +++++++
 rtl/vga_frame_scheduler.sv | 87 ++++++++
 tb/tb_vga_frame_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and the frame-memory scheduler state type.
// Ports: none (package shared by vga_sync_counter and vga_frame_scheduler).
package vga_timing_pkg;
    localparam logic [15:0] VGA_H_ACTIVE    = 16'd640;
    localparam logic [15:0] VGA_H_FP        = 16'd16;
    localparam logic [15:0] VGA_H_SYNC      = 16'd96;
    localparam logic [15:0] VGA_H_BP        = 16'd48;
    localparam logic [15:0] VGA_H_TOTAL     = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam logic [15:0] VGA_V_ACTIVE    = 16'd480;
    localparam logic [15:0] VGA_V_FP        = 16'd10;
    localparam logic [15:0] VGA_V_SYNC      = 16'd2;
    localparam logic [15:0] VGA_V_BP        = 16'd33;
    localparam logic [15:0] VGA_V_TOTAL     = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam logic [15:0] VGA_GUARD_LINES = 16'd2;

    typedef enum logic [1:0] {IDLE, WAIT_BLK, GRANTED, RELEASE} sched_state_e;
endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: h/v pixel counters with registered hsync/vsync/video_on/frame_start.
// Ports: clk_i, rst_i (sync, active-high); h_count_o/v_count_o current position;
//        h_next_o/v_next_o position of the next cycle; hsync_o/vsync_o active-low syncs;
//        video_on_o visible-area flag; frame_start_o pulse at position 0/0.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter logic [15:0] H_ACTIVE = VGA_H_ACTIVE,
    parameter logic [15:0] H_FP     = VGA_H_FP,
    parameter logic [15:0] H_SYNC   = VGA_H_SYNC,
    parameter logic [15:0] H_BP     = VGA_H_BP,
    parameter logic [15:0] V_ACTIVE = VGA_V_ACTIVE,
    parameter logic [15:0] V_FP     = VGA_V_FP,
    parameter logic [15:0] V_SYNC   = VGA_V_SYNC,
    parameter logic [15:0] V_BP     = VGA_V_BP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] h_count_o,
    output logic [15:0] v_count_o,
    output logic [15:0] h_next_o,
    output logic [15:0] v_next_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        video_on_o,
    output logic        frame_start_o
);
    localparam logic [15:0] H_LAST   = H_ACTIVE + H_FP + H_SYNC + H_BP - 16'd1;
    localparam logic [15:0] V_LAST   = V_ACTIVE + V_FP + V_SYNC + V_BP - 16'd1;
    localparam logic [15:0] HS_FIRST = H_ACTIVE + H_FP;
    localparam logic [15:0] HS_LAST  = HS_FIRST + H_SYNC - 16'd1;
    localparam logic [15:0] VS_FIRST = V_ACTIVE + V_FP;
    localparam logic [15:0] VS_LAST  = VS_FIRST + V_SYNC - 16'd1;

    logic [15:0] h_q, v_q, h_d, v_d;
    logic        hs_q, vs_q, vid_q, fs_q;

    always_comb begin
        h_d = (h_q == H_LAST) ? 16'd0 : h_q + 16'd1;
        v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
    end

    // Flags are derived from the next position so they line up with the counters they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q   <= 16'd0;
            v_q   <= 16'd0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vid_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= !(h_d >= HS_FIRST && h_d <= HS_LAST);
            vs_q  <= !(v_d >= VS_FIRST && v_d <= VS_LAST);
            vid_q <= (h_d < H_ACTIVE) && (v_d < V_ACTIVE);
            fs_q  <= (h_d == 16'd0) && (v_d == 16'd0);
        end
    end

    assign h_count_o     = h_q;
    assign v_count_o     = v_q;
    assign h_next_o      = h_d;
    assign v_next_o      = v_d;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign video_on_o    = vid_q;
    assign frame_start_o = fs_q;
endmodule

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: VGA timing plus vertical-blanking-only frame-memory access arbitration.
// Ports: clk_25MHz, reset (sync, active-high); h_count/v_count position; hsync/vsync active-low;
//        video_on, frame_start; upd_req (level) / upd_grant / upd_done (pulse) handshake with the
//        game-state writer; upd_abort pulses when a grant is revoked at the end of blanking.
module vga_frame_scheduler
    import vga_timing_pkg::*;
#(
    parameter logic [15:0] H_ACTIVE    = VGA_H_ACTIVE,
    parameter logic [15:0] H_FP        = VGA_H_FP,
    parameter logic [15:0] H_SYNC      = VGA_H_SYNC,
    parameter logic [15:0] H_BP        = VGA_H_BP,
    parameter logic [15:0] V_ACTIVE    = VGA_V_ACTIVE,
    parameter logic [15:0] V_FP        = VGA_V_FP,
    parameter logic [15:0] V_SYNC      = VGA_V_SYNC,
    parameter logic [15:0] V_BP        = VGA_V_BP,
    parameter logic [15:0] GUARD_LINES = VGA_GUARD_LINES
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    output logic [15:0] h_count,
    output logic [15:0] v_count,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start,
    input  logic        upd_req,
    output logic        upd_grant,
    input  logic        upd_done,
    output logic        upd_abort
);
    localparam logic [15:0] V_LAST  = V_ACTIVE + V_FP + V_SYNC + V_BP - 16'd1;
    localparam logic [15:0] WIN_END = V_LAST - GUARD_LINES;

    logic [15:0]  h_next, v_next;
    logic         win_n, abort_pt_n, frame_n, abort_d, abort_q;
    sched_state_e state_q, state_d;

    vga_sync_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_cnt (
        .clk_i(clk_25MHz),
        .rst_i(reset),
        .h_count_o(h_count),
        .v_count_o(v_count),
        .h_next_o(h_next),
        .v_next_o(v_next),
        .hsync_o(hsync),
        .vsync_o(vsync),
        .video_on_o(video_on),
        .frame_start_o(frame_start)
    );

    // Decisions look at the next position so grant/abort change on the exact cycle they name.
    assign win_n      = (v_next >= V_ACTIVE) && (v_next <= WIN_END);
    assign abort_pt_n = (v_next == V_LAST) && (h_next == 16'd0);
    assign frame_n    = (v_next == 16'd0) && (h_next == 16'd0);

    always_comb begin
        state_d = state_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE:     state_d = !upd_req ? IDLE : win_n ? GRANTED : WAIT_BLK;
            WAIT_BLK: state_d = !upd_req ? IDLE : win_n ? GRANTED : WAIT_BLK;
            GRANTED: begin
                state_d = (upd_done || abort_pt_n) ? RELEASE : GRANTED;
                abort_d = abort_pt_n && !upd_done;
            end
            // A held request re-arms only at the next frame, giving at most one grant per frame.
            RELEASE:  state_d = (!upd_req || frame_n) ? IDLE : RELEASE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

    assign upd_grant = (state_q == GRANTED);
    assign upd_abort = abort_q;
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: directed checks of timing and grant handshake on a scaled and a full-size instance.
module tb_vga_frame_scheduler;
    localparam int FRAME = 600;

    logic        clk, reset, upd_req, upd_done;
    logic [15:0] h_count, v_count, d_h, d_v;
    logic        hsync, vsync, video_on, frame_start, upd_grant, upd_abort;
    logic        d_hs, d_vs, d_vid, d_fs, d_grant, d_abort;
    int          n_cmp = 0, n_err = 0, ab_cnt = 0, g_rise = 0;
    logic        g_prev = 1'b0;

    vga_frame_scheduler #(
        .H_ACTIVE(16'd20), .H_FP(16'd2), .H_SYNC(16'd4), .H_BP(16'd4),
        .V_ACTIVE(16'd12), .V_FP(16'd2), .V_SYNC(16'd2), .V_BP(16'd4),
        .GUARD_LINES(16'd2)
    ) dut (
        .clk_25MHz(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start),
        .upd_req(upd_req), .upd_grant(upd_grant), .upd_done(upd_done), .upd_abort(upd_abort)
    );

    vga_frame_scheduler dut_full (
        .clk_25MHz(clk), .reset(reset), .h_count(d_h), .v_count(d_v),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_vid), .frame_start(d_fs),
        .upd_req(1'b0), .upd_grant(d_grant), .upd_done(1'b0), .upd_abort(d_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_pos(input int v, input int h);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(v_count == v[15:0] && h_count == h[15:0]) && n < FRAME + 100);
        if (!(v_count == v[15:0] && h_count == h[15:0]))
            chk("wait_pos", {v_count, h_count}, {v[15:0], h[15:0]});
    endtask

    always @(negedge clk) begin
        if (upd_grant && video_on) chk("grant_vs_video", 32'd1, 32'd0);
        if (d_grant || d_abort) chk("full_idle_handshake", 32'd1, 32'd0);
        if (upd_abort) ab_cnt++;
        if (upd_grant && !g_prev) g_rise++;
        g_prev = upd_grant;
    end

    initial begin
        int fs_n, fs_first, fs_second, hs_n, hs_first, vs_n, vs_first, vid_n, dhs_n, dhs_first, ab0, g0;
        reset = 1'b1; upd_req = 1'b0; upd_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_h", h_count, 0);
        chk("rst_v", v_count, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_video_on", video_on, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_grant", upd_grant, 0);
        chk("rst_abort", upd_abort, 0);
        reset = 1'b0;
        // two frames of free-running timing
        fs_n = 0; fs_first = -1; fs_second = -1; hs_n = 0; hs_first = -1;
        vs_n = 0; vs_first = -1; vid_n = 0; dhs_n = 0; dhs_first = -1;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_n++;
                if (fs_first < 0) fs_first = i; else fs_second = i;
            end
            if (!hsync) begin hs_n++; if (hs_first < 0) hs_first = i; end
            if (!vsync) begin vs_n++; if (vs_first < 0) vs_first = i; end
            if (video_on) vid_n++;
            if (i < 800 && !d_hs) begin dhs_n++; if (dhs_first < 0) dhs_first = i; end
            if (i == 1) chk("first_h", h_count, 1);
            if (i == 639) chk("full_vid_h639", d_vid, 1);
            if (i == 640) chk("full_vid_h640", d_vid, 0);
            if (i == 800) chk("full_wrap", {d_v, d_h}, {16'd1, 16'd0});
        end
        chk("fs_count", fs_n, 2);
        chk("fs_first", fs_first, FRAME);
        chk("fs_period", fs_second - fs_first, FRAME);
        chk("hs_first", hs_first, 22);
        chk("hs_low_total", hs_n, 160);
        chk("vs_first", vs_first, 14 * 30);
        chk("vs_low_total", vs_n, 120);
        chk("video_total", vid_n, 480);
        chk("full_hs_first", dhs_first, 656);
        chk("full_hs_width", dhs_n, 96);
        chk("no_grant_idle", g_rise, 0);
        // request in active video, granted at start of blanking, released by done
        ab0 = ab_cnt;
        wait_pos(3, 5); upd_req = 1'b1;
        wait_pos(11, 29); chk("t2_pre_grant", upd_grant, 0);
        @(negedge clk);
        chk("t2_grant_pos", {v_count, h_count}, {16'd12, 16'd0});
        chk("t2_grant", upd_grant, 1);
        wait_pos(14, 7); upd_done = 1'b1;
        chk("t2_grant_at_done", upd_grant, 1);
        @(negedge clk); upd_done = 1'b0; upd_req = 1'b0;
        chk("t2_grant_after_done", upd_grant, 0);
        wait_pos(0, 0);
        chk("t2_no_abort", ab_cnt - ab0, 0);
        // request in blanking, no done: revoked at last line
        wait_pos(13, 3); upd_req = 1'b1;
        chk("t3_pre_grant", upd_grant, 0);
        @(negedge clk); chk("t3_grant_next", upd_grant, 1);
        wait_pos(18, 29);
        chk("t3_grant_held", upd_grant, 1);
        chk("t3_abort_pre", upd_abort, 0);
        @(negedge clk); upd_req = 1'b0;
        chk("t3_abort_pos", {v_count, h_count}, {16'd19, 16'd0});
        chk("t3_grant_fall", upd_grant, 0);
        chk("t3_abort", upd_abort, 1);
        @(negedge clk); chk("t3_abort_1cyc", upd_abort, 0);
        // request held over three frames, one done per frame
        wait_pos(0, 0);
        g0 = g_rise; ab0 = ab_cnt; upd_req = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_pos(14, 0);
            chk("t4_granted", upd_grant, 1);
            upd_done = 1'b1;
            @(negedge clk); upd_done = 1'b0;
        end
        wait_pos(0, 0);
        chk("t4_grants", g_rise - g0, 3);
        chk("t4_no_abort", ab_cnt - ab0, 0);
        upd_req = 1'b0;
        // request inside the guard band waits for next frame
        wait_pos(18, 4); upd_req = 1'b1; g0 = g_rise;
        wait_pos(11, 29);
        chk("t5_no_early_grant", g_rise - g0, 0);
        chk("t5_pre_grant", upd_grant, 0);
        @(negedge clk);
        chk("t5_grant_pos", {v_count, h_count}, {16'd12, 16'd0});
        chk("t5_grant", upd_grant, 1);
        upd_done = 1'b1;
        @(negedge clk); upd_done = 1'b0; upd_req = 1'b0;
        // reset during a grant
        wait_pos(5, 0); upd_req = 1'b1;
        wait_pos(14, 10);
        chk("t6_granted", upd_grant, 1);
        ab0 = ab_cnt; reset = 1'b1;
        @(negedge clk);
        chk("t6_grant", upd_grant, 0);
        chk("t6_pos", {v_count, h_count}, {16'd0, 16'd0});
        chk("t6_abort", upd_abort, 0);
        chk("t6_syncs", {hsync, vsync, video_on, frame_start}, 4'b1100);
        reset = 1'b0; upd_req = 1'b0;
        @(negedge clk);
        chk("t6_restart", {v_count, h_count}, {16'd0, 16'd1});
        chk("t6_video", video_on, 1);
        repeat (20) @(negedge clk);
        chk("t6_no_abort", ab_cnt - ab0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
